dino_frame_scheduler: RTL and testbench
=======================================

# dino_frame_scheduler

Frame-update controller for the Dino renderer. On each game tick it snapshots game state, then drives the raster coordinate into the per-pixel renderer (sprite/cactus/bird/score compositor plus its synchronous sprite ROMs). It pairs each coordinate's `updatePixel` flag with the ROM-delayed RGB result and streams only changed pixels to the framebuffer writer over a valid/ready interface. It sits between the game-logic tick, the pixel renderer and the framebuffer port.

## Interface
Parameters:
- `H_RES`, 800, visible width in pixels.
- `V_RES`, 600, visible height in pixels.
- `ROM_LATENCY`, 1, cycles from `scan_x/scan_y` to valid `render_r/g/b`; range 1–3.
- `FIFO_DEPTH`, 4, output FIFO entries; must be ≥ `ROM_LATENCY`+1.
- `ADDR_W`, 19, framebuffer address width; `H_RES*V_RES` ≤ 2^`ADDR_W`.

Ports:
- `clock`  in  1  sole clock; also drives the renderer ROMs.
- `reset`  in  1  synchronous, active-high.
- `frame_start`  in  1  one-cycle game-tick pulse.
- `snapshot_en`  out  1  one-cycle pulse; renderer latches current and previous game state.
- `scan_x`  out  11  coordinate presented to the renderer.
- `scan_y`  out  11  coordinate presented to the renderer.
- `scan_issue`  out  1  the current `scan_x/scan_y` is a new, counted coordinate.
- `render_update`  in  1  combinational `updatePixel` for the current `scan_x/scan_y`.
- `render_r`, `render_g`, `render_b`  in  8 each  renderer colour, valid `ROM_LATENCY` cycles after the coordinate.
- `wr_valid`  out  1  framebuffer write request.
- `wr_ready`  in  1  framebuffer accepts.
- `wr_addr`  out  `ADDR_W`  `y*H_RES+x`.
- `wr_data`  out  16  `{1'b1, r[7:3], g[7:3], b[7:3]}`.
- `busy`  out  1  state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse when a frame is fully written.
- `skip_count`  out  8  saturating count of ignored `frame_start` pulses.

## Operation
- States: IDLE → SNAP → SCAN → DRAIN → DONE → IDLE.
- IDLE: `frame_start` moves to SNAP. Otherwise hold.
- SNAP: one cycle. `snapshot_en`=1. Clear `scan_x`, `scan_y` to 0. Go to SCAN.
- SCAN: issue a coordinate when `fifo_count + inflight < FIFO_DEPTH`.
  - On issue: `scan_issue`=1. Sample `render_update` and the computed address into slot 0 of a `ROM_LATENCY`-deep shift pipeline.
  - Advance raster x-fastest; `x` wraps at `H_RES-1` and increments `y`.
  - After issuing (`H_RES-1`, `V_RES-1`), go to DRAIN. Coordinates then hold at the last value.
  - No issue: `scan_x/scan_y` hold and `scan_issue`=0.
- Pipeline: always shifts and never stalls. At the tail, the entry is pushed into the FIFO only if the entry is valid and its update flag is 1. RGB is packed at that moment. Non-update entries are discarded.
- DRAIN: wait until the pipeline and FIFO are both empty, then go to DONE.
- DONE: one cycle. `frame_done`=1. Go to IDLE.
- `frame_start` outside IDLE is ignored. `skip_count` increments and saturates at 255.
- Credit rule: the FIFO can never overflow, so render data is never dropped.

## Timing
- Reset values: state IDLE; `snapshot_en`, `scan_issue`, `wr_valid`, `busy`, `frame_done` = 0; `scan_x`, `scan_y`, `wr_addr`, `wr_data`, `skip_count` = 0. Pipeline and FIFO are empty.
- Reset mid-frame: the next cycle is IDLE with no writes. Partial-frame FIFO contents are discarded.
- `frame_start` at cycle 0 produces `snapshot_en` at cycle 1. The first issue (0,0) is at cycle 2.
- Push occurs at the end of cycle 2+`ROM_LATENCY`. `wr_valid` can be high from cycle 3+`ROM_LATENCY`.
- FIFO is first-word-fall-through on registered outputs. Pop on `wr_valid && wr_ready`.
- Simultaneous push and pop keeps the count unchanged.
- `wr_valid` stays high and `wr_addr/wr_data` stay stable until accepted.
- Throughput: one coordinate per cycle when `wr_ready`=1 and `FIFO_DEPTH` ≥ `ROM_LATENCY`+2.
- Address computation: `y*H_RES+x` truncated to `ADDR_W` bits, with no overflow for legal parameters.

## Structure
- `dino_pkg`: `H_RES`/`V_RES` defaults, the state enum, and an RGB888→1555 pack function.
- Sub-module `dino_wr_fifo`: parameterised-depth FWFT FIFO providing count, push, pop, empty and full.

## Test plan
- `H_RES`=8, `V_RES`=4, `wr_ready`=1, `render_update`=1 always → 32 writes, addresses 0..31 in order. `frame_done` is 1 cycle after the last acceptance. No bubbles after the first write.
- Same setup, `render_update`=1 only for x=3 → exactly 4 writes at addresses 3, 11, 19, 27.
- `wr_ready` toggling 1-of-3 cycles, `render_r/g/b` = f(x,y) → every written `wr_data` matches the pack of f at its address. `fifo_count` never exceeds `FIFO_DEPTH`. `wr_data` stays stable while stalled.
- Each of `ROM_LATENCY`=1, 2, 3 with `FIFO_DEPTH`=`ROM_LATENCY`+1 → correct data alignment at all depths, with no loss.
- `frame_start` pulsed 3 times mid-SCAN → `skip_count`=3 and the frame completes normally. A run of 300 such pulses → `skip_count`=255.
- `reset` asserted at pixel 10 with 2 writes pending → next cycle `busy`=0, `wr_valid`=0. A new `frame_start` then restarts at (0,0).

Source files
------------

// File: rtl/dino_pkg.sv
// Shared definitions for the Dino frame scheduler: raster defaults, FSM states, pixel packing.
package dino_pkg;

  localparam int unsigned H_RES_DEFAULT = 800;
  localparam int unsigned V_RES_DEFAULT = 600;
  localparam int unsigned COORD_W       = 11;

  typedef enum logic [2:0] {
    StIdle,
    StSnap,
    StScan,
    StDrain,
    StDone
  } sched_state_e;

  // RGB888 -> 1555 with the alpha/valid bit forced on.
  function automatic logic [15:0] pack_rgb1555(input logic [7:0] r, input logic [7:0] g,
                                               input logic [7:0] b);
    return {1'b1, r[7:3], g[7:3], b[7:3]};
  endfunction

endpackage

// File: rtl/dino_wr_fifo.sv
// First-word-fall-through FIFO; the head entry is read straight from the storage registers.
module dino_wr_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 35
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [Width-1:0]           push_data,
  input  logic                       pop,
  output logic [Width-1:0]           pop_data,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign do_pop   = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO may still accept.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dino_frame_scheduler.sv
// Per-tick frame walker: snapshots game state, scans the raster through the renderer and
// streams changed pixels to the framebuffer writer.
module dino_frame_scheduler
  import dino_pkg::*;
#(
  parameter int unsigned H_RES       = H_RES_DEFAULT,
  parameter int unsigned V_RES       = V_RES_DEFAULT,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ADDR_W      = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  output logic              snapshot_en,
  output logic [10:0]       scan_x,
  output logic [10:0]       scan_y,
  output logic              scan_issue,
  input  logic              render_update,
  input  logic [7:0]        render_r,
  input  logic [7:0]        render_g,
  input  logic [7:0]        render_b,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        skip_count
);

  localparam int unsigned DataW = ADDR_W + 16;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  sched_state_e            state_q, state_d;
  logic [COORD_W-1:0]      scan_x_q, scan_x_d, scan_y_q, scan_y_d;
  logic [7:0]              skip_q;
  logic                    issue;
  logic [ADDR_W-1:0]       issue_addr;
  logic [ROM_LATENCY-1:0]  pipe_vld_q, pipe_upd_q;
  logic [ADDR_W-1:0]       pipe_addr_q [ROM_LATENCY];
  int unsigned             inflight;
  logic                    credit_ok, drain_done;
  logic                    push, pop, fifo_empty, fifo_full;
  logic [CntW-1:0]         fifo_count;
  logic [DataW-1:0]        fifo_out;

  assign issue_addr = ADDR_W'(32'(scan_y_q) * H_RES + 32'(scan_x_q));

  always_comb begin
    inflight = 0;
    for (int i = 0; i < int'(ROM_LATENCY); i++) begin
      inflight += 32'(pipe_vld_q[i]);
    end
  end

  // Every in-flight coordinate holds a reserved FIFO slot, so pushes can never overflow.
  assign credit_ok  = (32'(fifo_count) + inflight) < FIFO_DEPTH;
  assign push       = pipe_vld_q[ROM_LATENCY-1] & pipe_upd_q[ROM_LATENCY-1];
  assign pop        = ~fifo_empty & wr_ready;
  // Look one cycle ahead so DONE follows the last acceptance immediately.
  assign drain_done = (32'(fifo_count) + 32'(push) - 32'(pop) == 32'd0) &&
                      (inflight - 32'(pipe_vld_q[ROM_LATENCY-1]) == 32'd0);

  always_comb begin
    state_d  = state_q;
    scan_x_d = scan_x_q;
    scan_y_d = scan_y_q;
    issue    = 1'b0;
    case (state_q)
      StIdle: begin
        if (frame_start) state_d = StSnap;
      end
      StSnap: begin
        scan_x_d = '0;
        scan_y_d = '0;
        state_d  = StScan;
      end
      StScan: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (scan_x_q == COORD_W'(H_RES - 1)) begin
            if (scan_y_q == COORD_W'(V_RES - 1)) begin
              state_d = StDrain;
            end else begin
              scan_x_d = '0;
              scan_y_d = scan_y_q + 1'b1;
            end
          end else begin
            scan_x_d = scan_x_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (drain_done) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      scan_x_q   <= '0;
      scan_y_q   <= '0;
      skip_q     <= '0;
      pipe_vld_q <= '0;
      pipe_upd_q <= '0;
      for (int i = 0; i < int'(ROM_LATENCY); i++) begin
        pipe_addr_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      scan_x_q <= scan_x_d;
      scan_y_q <= scan_y_d;
      if (frame_start && (state_q != StIdle) && (skip_q != 8'hFF)) begin
        skip_q <= skip_q + 1'b1;
      end
      // Fixed-length delay line matching the renderer ROM latency; never stalls.
      pipe_vld_q[0]  <= issue;
      pipe_upd_q[0]  <= issue & render_update;
      pipe_addr_q[0] <= issue_addr;
      for (int i = 1; i < int'(ROM_LATENCY); i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_upd_q[i]  <= pipe_upd_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

  dino_wr_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DataW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({pipe_addr_q[ROM_LATENCY-1], pack_rgb1555(render_r, render_g, render_b)}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assert property (@(posedge clock) disable iff (reset) !(push && fifo_full && !pop));

  assign snapshot_en = (state_q == StSnap);
  assign scan_x      = scan_x_q;
  assign scan_y      = scan_y_q;
  assign scan_issue  = issue;
  assign wr_valid    = ~fifo_empty;
  assign wr_addr     = fifo_out[DataW-1:16];
  assign wr_data     = fifo_out[15:0];
  assign busy        = (state_q != StIdle);
  assign frame_done  = (state_q == StDone);
  assign skip_count  = skip_q;

endmodule

// File: tb/tb_dino_frame_scheduler.sv
// Directed bench: four scheduler instances (latency/depth variants) on an 8x4 raster.
module tb_dino_frame_scheduler;

  localparam int unsigned HR = 8;
  localparam int unsigned VR = 4;
  localparam int unsigned NI = 4;

  logic clock = 1'b0;
  logic reset, frame_start, wr_ready, clr;
  logic upd_mode, rdy_mode, ord_en, fd_chk;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   exp_addr[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] f_rgb(input logic [10:0] x, input logic [10:0] y);
    return {x[2:0], y[1:0], 3'b111, ~y[1:0], x[2:0], 3'b000, x[0], y[1:0], x[2:1], 3'b010};
  endfunction

  // Hand-packed form of f_rgb: r[7:3]={x,y}, g[7:3]={~y,x}, b[7:3]={x0,y,x2:1}.
  function automatic logic [15:0] exp_pix(input logic [18:0] a);
    logic [2:0] x;
    logic [1:0] y;
    x = a[2:0];
    y = a[4:3];
    return {1'b1, x, y, ~y, x, x[0], y, x[2:1]};
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int unsigned L = (k == 0) ? 1 : k;
    localparam int unsigned D = (k == 0) ? 4 : k + 1;

    logic [10:0] scan_x, scan_y;
    logic        snapshot_en, scan_issue, render_update, wr_valid, busy, frame_done;
    logic [7:0]  render_r, render_g, render_b, skip_count;
    logic [18:0] wr_addr;
    logic [15:0] wr_data;
    logic [23:0] rom_q [3];
    int          wr_idx, first_acc, last_acc;
    bit          done_seen, ovf, stall_q;
    logic [34:0] held;

    dino_frame_scheduler #(
      .H_RES       (HR),
      .V_RES       (VR),
      .ROM_LATENCY (L),
      .FIFO_DEPTH  (D),
      .ADDR_W      (19)
    ) u_dut (
      .clock         (clock),
      .reset         (reset),
      .frame_start   (frame_start),
      .snapshot_en   (snapshot_en),
      .scan_x        (scan_x),
      .scan_y        (scan_y),
      .scan_issue    (scan_issue),
      .render_update (render_update),
      .render_r      (render_r),
      .render_g      (render_g),
      .render_b      (render_b),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .busy          (busy),
      .frame_done    (frame_done),
      .skip_count    (skip_count)
    );

    // Renderer model: synchronous ROM of depth L, combinational update flag.
    always @(posedge clock) begin
      rom_q[0] <= f_rgb(scan_x, scan_y);
      rom_q[1] <= rom_q[0];
      rom_q[2] <= rom_q[1];
    end
    assign {render_r, render_g, render_b} = rom_q[L-1];
    assign render_update = upd_mode ? (scan_x == 11'd3) : 1'b1;

    always @(negedge clock) begin
      if (reset || clr) begin
        wr_idx    = 0;
        done_seen = 0;
        stall_q   = 0;
        ovf       = 0;
      end else begin
        if (stall_q) begin
          check_val($sformatf("d%0d_stall_hold", k), {wr_valid, wr_addr, wr_data}, {1'b1, held});
        end
        stall_q = wr_valid && !wr_ready;
        held    = {wr_addr, wr_data};
        if (wr_valid && wr_ready) begin
          check_val($sformatf("d%0d_data", k), wr_data, exp_pix(wr_addr));
          if (ord_en) begin
            check_val($sformatf("d%0d_addr", k), wr_addr,
                      (wr_idx < exp_addr.size()) ? exp_addr[wr_idx] : 64'hDEAD);
          end
          if (wr_idx == 0) first_acc = cyc;
          last_acc = cyc;
          wr_idx++;
        end
        if (frame_done) begin
          done_seen = 1;
          if (k == 0 && fd_chk) check_val("frame_done_cycle", cyc, last_acc + 1);
        end
        if (u_dut.u_fifo.count > D) ovf = 1;
      end
    end
  end

  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1 wr_ready = rdy_mode ? (cyc % 3 == 0) : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    @(posedge clock); #1 clr = 1'b1;
    @(posedge clock); #1 clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 frame_start = 1'b1;
    @(posedge clock); #1 frame_start = 1'b0;
  endtask

  task automatic set_full_raster();
    exp_addr.delete();
    for (int i = 0; i < int'(HR * VR); i++) exp_addr.push_back(i);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!(g_inst[0].done_seen && g_inst[1].done_seen && g_inst[2].done_seen &&
             g_inst[3].done_seen) && n < limit) begin
      @(negedge clock);
      n++;
    end
    check_val("wait_done", {g_inst[3].done_seen, g_inst[2].done_seen, g_inst[1].done_seen,
                            g_inst[0].done_seen}, 4'hF);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((g_inst[0].busy || g_inst[1].busy || g_inst[2].busy || g_inst[3].busy) &&
           n < limit) begin
      @(negedge clock);
      n++;
    end
    check_val("wait_idle", {g_inst[3].busy, g_inst[2].busy, g_inst[1].busy, g_inst[0].busy},
              4'h0);
  endtask

  task automatic check_frame(input string tag);
    check_val({tag, "_cnt0"}, g_inst[0].wr_idx, exp_addr.size());
    check_val({tag, "_cnt1"}, g_inst[1].wr_idx, exp_addr.size());
    check_val({tag, "_cnt2"}, g_inst[2].wr_idx, exp_addr.size());
    check_val({tag, "_cnt3"}, g_inst[3].wr_idx, exp_addr.size());
  endtask

  task automatic check_skip(input logic [7:0] exp);
    check_val("skip0", g_inst[0].skip_count, exp);
    check_val("skip1", g_inst[1].skip_count, exp);
    check_val("skip2", g_inst[2].skip_count, exp);
    check_val("skip3", g_inst[3].skip_count, exp);
  endtask

  initial begin
    int n;
    reset = 1'b1; frame_start = 1'b0; clr = 1'b0;
    upd_mode = 1'b0; rdy_mode = 1'b0; ord_en = 1'b1; fd_chk = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    check_val("rst_ctrl", {g_inst[0].busy, g_inst[0].wr_valid, g_inst[0].snapshot_en,
                           g_inst[0].scan_issue, g_inst[0].frame_done}, 5'd0);
    check_val("rst_scan", {g_inst[0].scan_x, g_inst[0].scan_y}, 22'd0);
    check_val("rst_wr", {g_inst[0].wr_addr, g_inst[0].wr_data}, 35'd0);
    check_val("rst_skip", g_inst[0].skip_count, 8'd0);

    // Full update, always ready: startup latency, order, no bubbles, done timing
    set_full_raster();
    fd_chk = 1'b1;
    clear_mon();
    pulse_start();
    @(negedge clock);
    check_val("snap_cycle", {g_inst[0].snapshot_en, g_inst[0].busy, g_inst[0].scan_issue},
              3'b110);
    @(negedge clock);
    check_val("first_issue", {g_inst[0].snapshot_en, g_inst[0].scan_issue, g_inst[0].scan_x,
                              g_inst[0].scan_y}, {2'b01, 22'd0});
    @(negedge clock);
    check_val("wr_valid_early", g_inst[0].wr_valid, 1'b0);
    @(negedge clock);
    check_val("first_write", {g_inst[0].wr_valid, g_inst[0].wr_addr, g_inst[0].wr_data},
              {1'b1, 19'd0, 16'h8300});
    wait_done(1000);
    check_frame("full");
    check_val("no_bubbles", g_inst[0].last_acc - g_inst[0].first_acc, 31);
    fd_chk = 1'b0;

    // Only x==3 changes
    upd_mode = 1'b1;
    exp_addr = '{3, 11, 19, 27};
    clear_mon();
    pulse_start();
    wait_done(1000);
    check_frame("sparse");
    upd_mode = 1'b0;

    // Backpressure 1-of-3: data alignment at every latency, no overflow
    rdy_mode = 1'b1;
    set_full_raster();
    clear_mon();
    pulse_start();
    wait_done(3000);
    check_frame("bp");
    check_val("no_ovf", {g_inst[3].ovf, g_inst[2].ovf, g_inst[1].ovf, g_inst[0].ovf}, 4'h0);
    rdy_mode = 1'b0;

    // Ignored frame_start while busy
    set_full_raster();
    clear_mon();
    pulse_start();
    repeat (4) @(posedge clock);
    repeat (3) pulse_start();
    wait_done(2000);
    check_frame("skip3");
    check_skip(8'd3);

    // Long run of frame_start saturates the counter
    ord_en = 1'b0;
    @(posedge clock); #1 frame_start = 1'b1;
    repeat (300) @(posedge clock);
    #1 frame_start = 1'b0;
    wait_idle(3000);
    check_skip(8'd255);
    ord_en = 1'b1;

    // Reset mid-frame, then restart from (0,0)
    rdy_mode = 1'b1;
    clear_mon();
    pulse_start();
    n = 0;
    while (!(g_inst[0].scan_issue && g_inst[0].scan_x == 11'd2 && g_inst[0].scan_y == 11'd1) &&
           n < 500) begin
      @(negedge clock);
      n++;
    end
    check_val("reach_px10", {g_inst[0].scan_x, g_inst[0].scan_y}, {11'd2, 11'd1});
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check_val("rst_mid_busy", {g_inst[3].busy, g_inst[2].busy, g_inst[1].busy, g_inst[0].busy},
              4'h0);
    check_val("rst_mid_valid", {g_inst[3].wr_valid, g_inst[2].wr_valid, g_inst[1].wr_valid,
                                g_inst[0].wr_valid}, 4'h0);
    rdy_mode = 1'b0;
    set_full_raster();
    clear_mon();
    pulse_start();
    @(negedge clock);
    @(negedge clock);
    check_val("restart_issue", {g_inst[0].scan_issue, g_inst[0].scan_x, g_inst[0].scan_y},
              {1'b1, 22'd0});
    wait_done(2000);
    check_frame("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
